// File: rtl/kaipokrandt_cpu_pkg.sv
// -----------------------------------------------------------------------------
// kaipokrandt_cpu_pkg
//   Shared definitions for the ALU sequencer and the ALU core decode:
//   opcode values, instruction field positions, sequencer state encoding and
//   small decode helpers.
//
//   Instruction word (16 bits):
//     [15:12] op   [11:10] rd   [9:8] rs1   [7:6] rs2 (R-type)
//                                           [7:0] imm8 (I-type, sign-extended)
// -----------------------------------------------------------------------------
package kaipokrandt_cpu_pkg;

   localparam int WORD_W = 16;

   // Opcodes; 10..15 are illegal
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SUBI = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_LDI  = 4'd9;

   // Instruction field positions (low bit of each field)
   localparam int OP_LO  = 12;
   localparam int OP_W   = 4;
   localparam int RD_LO  = 10;
   localparam int RS1_LO = 8;
   localparam int RS2_LO = 6;
   localparam int IMM_LO = 0;
   localparam int IMM_W  = 8;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_A    = 3'd1,
      S_B    = 3'd2,
      S_EXE  = 3'd3,
      S_WB   = 3'd4,
      S_LDI  = 3'd5,
      S_ERR  = 3'd6
   } seq_state_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_LDI);
   endfunction

   // ADDI/SUBI take the immediate as the second ALU operand
   function automatic logic op_uses_imm(input logic [3:0] op);
      return (op == OP_ADDI) || (op == OP_SUBI);
   endfunction

   // NOT has a single operand, so the in2 transfer is skipped
   function automatic logic op_is_unary(input logic [3:0] op);
      return (op == OP_NOT);
   endfunction

   function automatic logic signed [WORD_W-1:0] sext_imm(input logic [IMM_W-1:0] imm8);
      return {{(WORD_W-IMM_W){imm8[IMM_W-1]}}, imm8};
   endfunction

endpackage

// File: rtl/kaipokrandt_regfile.sv
// -----------------------------------------------------------------------------
// kaipokrandt_regfile
//   NREGS x DATA_W register file: two combinational read ports, one synchronous
//   write port. Asynchronous active-low reset clears every entry.
//
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low
//   rd_addr0   in   read port 0 index
//   rd_addr1   in   read port 1 index
//   rd_data0   out  read port 0 data (combinational)
//   rd_data1   out  read port 1 data (combinational)
//   wr_en      in   write enable, sampled at rising edge
//   wr_addr    in   write index
//   wr_data    in   write data
// -----------------------------------------------------------------------------
module kaipokrandt_regfile #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 4,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AW-1:0]     rd_addr0,
   input  logic [AW-1:0]     rd_addr1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs <= '{default: '0};
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data0 = regs[rd_addr0];
   assign rd_data1 = regs[rd_addr1];

endmodule

// File: rtl/kaipokrandt_alu_sequencer.sv
// -----------------------------------------------------------------------------
// kaipokrandt_alu_sequencer
//   Control stage in front of the 16-bit ALU core. Accepts one instruction per
//   valid/ready handshake, owns a 4x16 register file and sequences the shared
//   bus: operand A -> ALU in1, operand B or immediate -> ALU in2, execute,
//   ALU result -> rd. LDI writes the sign-extended immediate directly.
//
//   Sequences:  ALU op : IDLE -> A -> B -> EXE -> WB -> IDLE   (5 cycles)
//               NOT    : IDLE -> A -> EXE -> WB -> IDLE        (4 cycles)
//               LDI    : IDLE -> LDI -> IDLE                   (2 cycles)
//               illegal: IDLE -> ERR -> IDLE                   (2 cycles)
//
//   Ports
//     clk          in   clock, rising edge
//     reset        in   asynchronous, active-low
//     instr        in   instruction word
//     instr_valid  in   instruction offered
//     instr_ready  out  high only in IDLE
//     done         out  1-cycle retire pulse (also for illegal opcodes)
//     err          out  1-cycle pulse with done for illegal opcodes
//     bus_in       in   shared bus read-back (ALU result during WB)
//     bus_out      out  shared bus drive, high-Z when not owning the bus
//     in1_ld       out  ALU: load in1 from bus
//     in2_ld       out  ALU: load in2 from bus
//     out_ld       out  ALU: latch result
//     alu_op       out  ALU operation, latched at accept
//     alu_out_en   out  ALU tristate enable
//     flag_z       out  (KP_SEQ_FLAGS_EN only) last written value was zero
//     flag_n       out  (KP_SEQ_FLAGS_EN only) last written value was negative
//
//   Build option: define KP_SEQ_FLAGS_EN to add flag_z/flag_n.
// -----------------------------------------------------------------------------
module kaipokrandt_alu_sequencer
   import kaipokrandt_cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic              done,
   output logic              err,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              in1_ld,
   output logic              in2_ld,
   output logic              out_ld,
   output logic [3:0]        alu_op,
   output logic              alu_out_en
`ifdef KP_SEQ_FLAGS_EN
   ,
   output logic              flag_z,
   output logic              flag_n
`endif
);

   localparam int AW = $clog2(NREGS);

   seq_state_t                state;
   logic [AW-1:0]             rd_q;
   logic [AW-1:0]             rs2_q;
   logic signed [DATA_W-1:0]  imm_q;
   logic                      bus_drive;
   logic [DATA_W-1:0]         bus_data;

   logic [3:0]                op_in;
   logic signed [DATA_W-1:0]  imm_in;
   logic [DATA_W-1:0]         rf_rd0;
   logic [DATA_W-1:0]         rf_rd1;
   logic                      wr_en;
   logic [DATA_W-1:0]         wr_data;

   assign op_in  = instr[OP_LO +: OP_W];
   assign imm_in = sext_imm(instr[IMM_LO +: IMM_W]);

   // Port 0 reads rs1 straight from the offered instruction so operand A can
   // be registered onto the bus in the accept cycle. Port 1 reads the latched
   // rs2 during A, ahead of the B transfer. Both reads precede any writeback
   // of the same instruction, so rd may alias rs1/rs2.
   assign wr_en   = (state == S_WB) || (state == S_LDI);
   assign wr_data = (state == S_LDI) ? imm_q : bus_in;

   kaipokrandt_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (AW)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rd_addr0 (instr[RS1_LO +: AW]),
      .rd_addr1 (rs2_q),
      .rd_data0 (rf_rd0),
      .rd_data1 (rf_rd1),
      .wr_en    (wr_en),
      .wr_addr  (rd_q),
      .wr_data  (wr_data)
   );

   assign instr_ready = (state == S_IDLE);

   // Bus ownership is registered together with the state, so the bus is only
   // ever driven in A, B and LDI and always released in EXE and WB.
   assign bus_out = bus_drive ? bus_data : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         rd_q       <= '0;
         rs2_q      <= '0;
         imm_q      <= '0;
         alu_op     <= '0;
         bus_drive  <= 1'b0;
         bus_data   <= '0;
         in1_ld     <= 1'b0;
         in2_ld     <= 1'b0;
         out_ld     <= 1'b0;
         alu_out_en <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         // Strobes are single-cycle; each state below raises only its own
         in1_ld     <= 1'b0;
         in2_ld     <= 1'b0;
         out_ld     <= 1'b0;
         alu_out_en <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         bus_drive  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  rd_q  <= instr[RD_LO +: AW];
                  rs2_q <= instr[RS2_LO +: AW];
                  imm_q <= imm_in;
                  if (!op_is_legal(op_in)) begin
                     state <= S_ERR;
                  end else if (op_in == OP_LDI) begin
                     alu_op    <= op_in;
                     state     <= S_LDI;
                     bus_drive <= 1'b1;
                     bus_data  <= imm_in;
                  end else begin
                     alu_op    <= op_in;
                     state     <= S_A;
                     bus_drive <= 1'b1;
                     bus_data  <= rf_rd0;
                     in1_ld    <= 1'b1;
                  end
               end
            end

            S_A: begin
               if (op_is_unary(alu_op)) begin
                  state  <= S_EXE;
                  out_ld <= 1'b1;
               end else begin
                  state     <= S_B;
                  bus_drive <= 1'b1;
                  bus_data  <= op_uses_imm(alu_op) ? imm_q : rf_rd1;
                  in2_ld    <= 1'b1;
               end
            end

            S_B: begin
               state  <= S_EXE;
               out_ld <= 1'b1;
            end

            S_EXE: begin
               state      <= S_WB;
               alu_out_en <= 1'b1;
            end

            S_WB: begin
               state <= S_IDLE;
               done  <= 1'b1;
            end

            S_LDI: begin
               state <= S_IDLE;
               done  <= 1'b1;
            end

            S_ERR: begin
               state <= S_IDLE;
               done  <= 1'b1;
               err   <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef KP_SEQ_FLAGS_EN
   // Flags follow whatever value is written into the register file
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (wr_en) begin
         flag_z <= (wr_data == '0);
         flag_n <= wr_data[DATA_W-1];
      end
   end
`endif

endmodule

// File: tb/tb_kaipokrandt_alu_sequencer.sv
module tb_kaipokrandt_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        done;
   logic        err;
   logic [15:0] bus_in;
   wire  [15:0] bus_out;
   logic        in1_ld;
   logic        in2_ld;
   logic        out_ld;
   logic [3:0]  alu_op;
   logic        alu_out_en;
`ifdef KP_SEQ_FLAGS_EN
   logic        flag_z;
   logic        flag_n;
`endif

   always #5 clk = ~clk;

   kaipokrandt_alu_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .done        (done),
      .err         (err),
      .bus_in      (bus_in),
      .bus_out     (bus_out),
      .in1_ld      (in1_ld),
      .in2_ld      (in2_ld),
      .out_ld      (out_ld),
      .alu_op      (alu_op),
      .alu_out_en  (alu_out_en)
`ifdef KP_SEQ_FLAGS_EN
      ,
      .flag_z      (flag_z),
      .flag_n      (flag_n)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference register file (architectural view)
   logic [15:0] rf [4];

   // Observations from one instruction
   int          o_lat;
   logic        o_err;
   logic [15:0] o_in1, o_in2, o_c1;
   logic [27:0] o_sig;      // per cycle c: bits [4c+3:4c] = {in1_ld,in2_ld,out_ld,alu_out_en}
   logic        o_rdy0;
   int          o_rdy_bad;
   logic [15:0] alu_r;

   // Expectations from the model
   int          e_lat;
   logic        e_err;
   logic [15:0] e_in1, e_in2, e_c1;
   logic [27:0] e_sig;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   // ALU semantics (used by the bench's ALU stand-in and by the model)
   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0, 4'd1: return a + b;
         4'd2, 4'd3: return a - b;
         4'd4:       return ~a;
         4'd5:       return a & b;
         4'd6:       return a | b;
         4'd7:       return a ^ b;
         4'd8:       return ~(a ^ b);
         default:    return 16'h0000;
      endcase
   endfunction

   // Transaction-level model: expected latency, strobe timeline, operand
   // values seen on the bus, and architectural register update.
   task automatic model(input logic [15:0] ins);
      logic [3:0]  op;
      logic [1:0]  rd, rs1, rs2;
      logic [15:0] imm;
      op  = ins[15:12];
      rd  = ins[11:10];
      rs1 = ins[9:8];
      rs2 = ins[7:6];
      imm = sext8(ins[7:0]);
      e_err = 1'b0;
      e_sig = '0;
      e_c1  = imm;
      e_in1 = rf[rs1];
      e_in2 = (op == 4'd1 || op == 4'd3) ? imm : rf[rs2];
      if (op > 4'd9) begin
         e_lat = 2;
         e_err = 1'b1;
      end else if (op == 4'd9) begin
         e_lat  = 2;
         rf[rd] = imm;
      end else if (op == 4'd4) begin
         e_lat     = 4;
         e_sig[7]  = 1'b1;
         e_sig[9]  = 1'b1;
         e_sig[12] = 1'b1;
         rf[rd]    = ~e_in1;
      end else begin
         e_lat     = 5;
         e_sig[7]  = 1'b1;
         e_sig[10] = 1'b1;
         e_sig[13] = 1'b1;
         e_sig[16] = 1'b1;
         rf[rd]    = alu_f(op, e_in1, e_in2);
      end
   endtask

   // Offers one instruction at a negedge and follows it until done (bounded).
   // The bench also plays the ALU: it captures in1/in2 from the bus, computes
   // on out_ld and returns the result on bus_in while alu_out_en is high.
   // While busy, instr/instr_valid are scrambled to show they are ignored.
   task automatic exec(input logic [15:0] ins);
      o_rdy0    = instr_ready;
      o_rdy_bad = 0;
      o_sig     = '0;
      o_lat     = 99;
      o_err     = 1'b0;
      o_in1     = 16'h0;
      o_in2     = 16'h0;
      o_c1      = 16'h0;
      instr       = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 8; c++) begin
         if (c <= 6) o_sig[c*4 +: 4] = {in1_ld, in2_ld, out_ld, alu_out_en};
         if (in1_ld) o_in1 = bus_out;
         if (in2_ld) o_in2 = bus_out;
         if (c == 1) o_c1 = bus_out;
         if (out_ld) alu_r = alu_f(alu_op, o_in1, o_in2);
         bus_in = alu_out_en ? alu_r : 16'($urandom);
         if (done) begin
            o_lat = c;
            o_err = err;
            instr_valid = 1'b0;
            break;
         end
         if (instr_ready) o_rdy_bad++;
         instr_valid = 1'($urandom_range(0, 1));
         instr       = 16'($urandom);
         @(negedge clk);
      end
      instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      instr = 16'h0;
      instr_valid = 1'b0;
      bus_in = 16'h0;
      alu_r = 16'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({done, err} !== 2'b00) begin
         failures++; $display("FAIL reset_done_err got=%b exp=00", {done, err});
      end
      checks++;
      if ({in1_ld, in2_ld, out_ld, alu_out_en} !== 4'b0000) begin
         failures++; $display("FAIL reset_strobes got=%b exp=0000", {in1_ld, in2_ld, out_ld, alu_out_en});
      end
      checks++;
      if (alu_op !== 4'd0) begin
         failures++; $display("FAIL reset_alu_op got=%0d exp=0", alu_op);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready);
      end
      for (int i = 0; i < 4; i++) rf[i] = 16'h0;
   endtask

   task automatic test_spec_sequence();
      logic [15:0] prog [10];
      prog = '{16'h9405, 16'h9803, 16'h0D80, 16'h31FF, 16'h9480,
               16'h947F, 16'h157F, 16'h1501, 16'h4900, 16'h5280};
      for (int i = 0; i < 10; i++) begin
         model(prog[i]);
         exec(prog[i]);
         checks++;
         if (o_lat !== e_lat) begin
            failures++; $display("FAIL seq%0d_latency got=%0d exp=%0d", i, o_lat, e_lat);
         end
         checks++;
         if (o_sig !== e_sig) begin
            failures++; $display("FAIL seq%0d_strobes got=%h exp=%h", i, o_sig, e_sig);
         end
         if (prog[i][15:12] != 4'd9) begin
            checks++;
            if (o_in1 !== e_in1) begin
               failures++; $display("FAIL seq%0d_in1 got=%h exp=%h", i, o_in1, e_in1);
            end
         end
         if (i == 2) begin
            checks++;
            if (alu_r !== 16'h0008 || o_lat !== 5) begin
               failures++; $display("FAIL add_r3 got=%h/%0d exp=0008/5", alu_r, o_lat);
            end
         end
         if (i == 3) begin
            checks++;
            if (o_in2 !== 16'hFFFF || alu_r !== 16'h0006) begin
               failures++; $display("FAIL subi_imm got=%h/%h exp=ffff/0006", o_in2, alu_r);
            end
         end
         if (i == 4) begin
            checks++;
            if (o_c1 !== 16'hFF80) begin
               failures++; $display("FAIL ldi_sext got=%h exp=ff80", o_c1);
            end
         end
         if (i == 8) begin
            checks++;
            if (alu_r !== 16'hFF00 || o_lat !== 4 || o_sig[10] !== 1'b0) begin
               failures++; $display("FAIL not_r2 got=%h/%0d/%b exp=ff00/4/0", alu_r, o_lat, o_sig[10]);
            end
         end
         if (i == 9) begin
            checks++;
            if (o_in1 !== 16'hFF00) begin
               failures++; $display("FAIL read_r2 got=%h exp=ff00", o_in1);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [15:0] ins;
      model(16'h9833);
      exec(16'h9833);
      ins = {4'hC, 12'hA9F};   // rd=r2, would clobber r2 if it wrote
      model(ins);
      exec(ins);
      checks++;
      if (o_lat !== 2 || o_err !== 1'b1) begin
         failures++; $display("FAIL illegal_done_err got=%0d/%b exp=2/1", o_lat, o_err);
      end
      checks++;
      if (o_sig !== 28'h0) begin
         failures++; $display("FAIL illegal_strobes got=%h exp=0", o_sig);
      end
      model(16'h5680);
      exec(16'h5680);
      checks++;
      if (o_in1 !== 16'h0033 || o_err !== 1'b0) begin
         failures++; $display("FAIL illegal_rf_kept got=%h/%b exp=0033/0", o_in1, o_err);
      end
   endtask

   task automatic test_reset_mid();
      instr = 16'h76C0;        // XOR r1,r2,r3
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_ld !== 1'b1) begin
         failures++; $display("FAIL xor_reach_exe got=%b exp=1", out_ld);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({in1_ld, in2_ld, out_ld, alu_out_en, done, err, alu_op} !== 10'b0 || instr_ready !== 1'b1) begin
         failures++; $display("FAIL midreset_outputs got=%b/%b exp=0/1",
                              {in1_ld, in2_ld, out_ld, alu_out_en, done, err, alu_op}, instr_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) rf[i] = 16'h0;
      @(negedge clk);
      model(16'h0C00);         // ADD r3,r0,r0
      exec(16'h0C00);
      checks++;
      if (o_lat !== 5 || o_in1 !== 16'h0 || o_in2 !== 16'h0 || alu_r !== 16'h0) begin
         failures++; $display("FAIL post_reset_add got=%0d/%h/%h/%h exp=5/0/0/0", o_lat, o_in1, o_in2, alu_r);
      end
   endtask

`ifdef KP_SEQ_FLAGS_EN
   task automatic test_flags();
      model(16'h9407); exec(16'h9407);     // LDI r1,#7
      model(16'h2140); exec(16'h2140);     // SUB r0,r1,r1
      checks++;
      if ({flag_z, flag_n} !== 2'b10) begin
         failures++; $display("FAIL flags_sub_zero got=%b exp=10", {flag_z, flag_n});
      end
      model(16'h98FE); exec(16'h98FE);     // LDI r2,#-2
      checks++;
      if ({flag_z, flag_n} !== 2'b01) begin
         failures++; $display("FAIL flags_ldi_neg got=%b exp=01", {flag_z, flag_n});
      end
      model(16'hF000); exec(16'hF000);     // illegal
      checks++;
      if ({flag_z, flag_n} !== 2'b01) begin
         failures++; $display("FAIL flags_illegal_hold got=%b exp=01", {flag_z, flag_n});
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] r;
      logic [3:0]  op;
      logic [15:0] ins;
      for (int n = 0; n < 200; n++) begin
         r   = $urandom;
         op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         ins = {op, r[11:0]};
         model(ins);
         exec(ins);
         checks++;
         if (o_lat !== e_lat || o_err !== e_err) begin
            failures++; $display("FAIL rnd%0d_lat_err ins=%h got=%0d/%b exp=%0d/%b", n, ins, o_lat, o_err, e_lat, e_err);
         end
         checks++;
         if (o_sig !== e_sig) begin
            failures++; $display("FAIL rnd%0d_strobes ins=%h got=%h exp=%h", n, ins, o_sig, e_sig);
         end
         checks++;
         if (o_rdy0 !== 1'b1 || o_rdy_bad !== 0) begin
            failures++; $display("FAIL rnd%0d_ready got=%b/%0d exp=1/0", n, o_rdy0, o_rdy_bad);
         end
         if (op < 4'd9) begin
            checks++;
            if (o_in1 !== e_in1) begin
               failures++; $display("FAIL rnd%0d_in1 ins=%h got=%h exp=%h", n, ins, o_in1, e_in1);
            end
         end
         if (op < 4'd9 && op != 4'd4) begin
            checks++;
            if (o_in2 !== e_in2) begin
               failures++; $display("FAIL rnd%0d_in2 ins=%h got=%h exp=%h", n, ins, o_in2, e_in2);
            end
         end
         if (op == 4'd9) begin
            checks++;
            if (o_c1 !== e_c1) begin
               failures++; $display("FAIL rnd%0d_ldi_bus ins=%h got=%h exp=%h", n, ins, o_c1, e_c1);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spec_sequence();
      test_illegal();
      test_reset_mid();
`ifdef KP_SEQ_FLAGS_EN
      test_flags();
`endif
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
